// File: rtl/bp_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_update_scheduler                                          |
// | Description : Shares a single-ported BHT/BTB between fetch lookups and a   |
// |               FIFO of resolved-branch updates with starvation control.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_update_scheduler #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3,
  parameter int PC_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lk_req,
  input  logic [PC_W-1:0]        lk_pc,
  output logic                   lk_gnt,
  input  logic                   upd_valid,
  input  logic [PC_W-1:0]        upd_pc,
  input  logic                   upd_taken,
  input  logic [PC_W-1:0]        upd_target,
  output logic                   upd_ready,
  input  logic                   flush,
  output logic                   tbl_en,
  output logic                   tbl_we,
  output logic [PC_W-1:0]        tbl_pc,
  output logic                   tbl_taken,
  output logic [PC_W-1:0]        tbl_target,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [c_ST_W-1:0]  c_STARVE_MAX = c_ST_W'(STARVE_MAX);
  localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LK   = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_active;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_ST_W-1:0]    r_starve;
  logic [PC_W-1:0]      r_tbl_pc;
  logic                 r_tbl_taken;
  logic [PC_W-1:0]      r_tbl_target;
  logic [PC_W-1:0]      r_q_pc     [DEPTH];
  logic                 r_q_taken  [DEPTH];
  logic [PC_W-1:0]      r_q_target [DEPTH];
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  // r_active holds off all activity for the first cycle after reset release
  assign upd_ready = r_active && !w_full;

  always_comb begin
    w_next = S_IDLE;
    if (!r_active)
      w_next = S_IDLE;
    else if (flush || w_empty)
      w_next = lk_req ? S_LK : S_IDLE;
    else if (!lk_req)
      w_next = S_UPD;
    else if ((r_starve == c_STARVE_MAX) || w_full)
      w_next = S_UPD;
    else
      w_next = S_LK;
    lk_gnt = (w_next == S_LK);
    w_pop  = (w_next == S_UPD);
    w_push = upd_valid && upd_ready && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_starve <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)
        r_starve <= '0;
      else if ((w_next == S_LK) && !w_empty && (r_starve < c_STARVE_MAX))
        r_starve <= r_starve + c_ST_W'(1);
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]     <= upd_pc;
      r_q_taken[r_wr_ptr]  <= upd_taken;
      r_q_target[r_wr_ptr] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl_pc     <= '0;
      r_tbl_taken  <= 1'b0;
      r_tbl_target <= '0;
    end else if (w_next == S_LK) begin
      r_tbl_pc     <= lk_pc;
    end else if (w_next == S_UPD) begin
      r_tbl_pc     <= r_q_pc[r_rd_ptr];
      r_tbl_taken  <= r_q_taken[r_rd_ptr];
      r_tbl_target <= r_q_target[r_rd_ptr];
    end
  end

  assign tbl_en     = (r_state != S_IDLE);
  assign tbl_we     = (r_state == S_UPD);
  assign tbl_pc     = r_tbl_pc;
  assign tbl_taken  = r_tbl_taken;
  assign tbl_target = r_tbl_target;
  assign q_count    = r_count;

endmodule
`default_nettype wire

// File: doc/bp_update_scheduler.md
BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, sets the update-queue entry count.
REQ-002 Parameter STARVE_MAX, default 3, sets the maximum consecutive lookup wins while updates are pending.
REQ-003 Parameter PC_W, default 5, sets the PC and target width.
REQ-004 clk  input  1  single clock; all state changes on the posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 lk_req  input  1  fetch requests a predictor lookup this cycle.
REQ-007 lk_pc  input  PC_W  lookup PC.
REQ-008 lk_gnt  output  1  lookup granted this cycle (combinational).
REQ-009 upd_valid  input  1  branch resolution offered.
REQ-010 upd_pc / upd_taken / upd_target  input  PC_W / 1 / PC_W  resolved branch PC, outcome and effective address.
REQ-011 upd_ready  output  1  queue can accept a resolution (combinational: count < DEPTH).
REQ-012 flush  input  1  synchronous queue clear.
REQ-013 tbl_en / tbl_we  output  1 / 1  registered table command valid; 1 = update write, 0 = lookup read.
REQ-014 tbl_pc / tbl_taken / tbl_target  output  PC_W / 1 / PC_W  registered command payload.
REQ-015 q_count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 The block shall share the single-ported BHT/BTB between the lookup port and the update queue, issuing at most one table command per cycle.
REQ-017 The update queue shall be a FIFO; a push occurs when upd_valid && upd_ready and captures {upd_pc, upd_taken, upd_target}.
REQ-018 No bypass: an entry pushed in cycle N shall first be eligible for issue in cycle N+1.
REQ-019 Arbitration FSM states: IDLE (no command), LK (lookup issued), UPD (update issued); the next state is chosen each cycle as below.
REQ-020 Queue empty: lk_req -> LK with lk_gnt=1; no lk_req -> IDLE.
REQ-021 Queue non-empty, no lk_req -> UPD (pop head).
REQ-022 Queue non-empty with lk_req -> UPD if starve_cnt == STARVE_MAX or count == DEPTH, else LK.
REQ-023 starve_cnt shall increment on every LK issue while the queue is non-empty, clear on every UPD issue, and never exceed STARVE_MAX.
REQ-024 tbl_* shall be registered, so a decision in cycle N appears on tbl_* in cycle N+1 with a latency of one.
REQ-025 Encoding: LK -> tbl_en=1, tbl_we=0, tbl_pc=lk_pc; UPD -> tbl_en=1, tbl_we=1, payload = queue head; IDLE -> tbl_en=0.
REQ-026 In IDLE the payload shall hold its previous value.
REQ-027 Simultaneous push and pop shall leave the count unchanged and be legal at any count < DEPTH.
REQ-028 At count == DEPTH, upd_ready=0 and any upd_valid shall be ignored.
REQ-029 Read and write pointers shall wrap modulo DEPTH.
REQ-030 flush shall take priority over push and pop in its cycle: count=0, pointers=0, starve_cnt=0, and no UPD issued; a lookup shall still be granted that cycle.
REQ-031 lk_gnt=0 whenever the decision is UPD; fetch shall hold lk_req and lk_pc until granted.

Reset
REQ-032 While rst_n=0: state IDLE, tbl_en=0, tbl_we=0, tbl_pc=0, tbl_taken=0, tbl_target=0, q_count=0, starve_cnt=0, pointers=0.
REQ-033 Combinational outputs during reset: lk_gnt=0, upd_ready=0.
REQ-034 Reset asserted mid-operation shall discard all queued updates; after deassertion the first command shall appear no earlier than the second posedge.

Verification
REQ-035 Lookup only: lk_req=1, lk_pc=0x0C for 3 cycles, queue empty -> lk_gnt=1 each cycle; tbl_en=1, tbl_we=0, tbl_pc=0x0C from the next cycle on.
REQ-036 Starvation: push 1 update {0x0D,1,0x09}, then hold lk_req=1 -> exactly 3 LK issues, then one UPD with tbl_pc=0x0D, tbl_taken=1, tbl_target=0x09, and lk_gnt=0 in the UPD decision cycle.
REQ-037 Full queue: 4 pushes with lk_req held -> q_count=4, upd_ready=0, a 5th upd_valid is dropped, and the next decision is UPD in FIFO order.
REQ-038 Wrap: 6 pushes and 6 pops interleaved with no lookups -> tbl_pc shows all 6 PCs in push order across pointer wrap.
REQ-039 Flush: q_count=3 plus flush with upd_valid=1 -> next cycle q_count=0, no UPD issued, starve_cnt=0.
REQ-040 Reset mid-operation: rst_n low with q_count=2 and tbl_en=1 -> tbl_en=0 and q_count=0 immediately, with no queued update issued after release.
